// File: rtl/ef_irq_mon_pkg.sv
// ef_irq_mon_pkg
//   Shared constants for the APB interrupt monitor: register offsets,
//   CTRL bit positions, the channel-count ceiling and the COUNT[i] offset helper.
package ef_irq_mon_pkg;

    localparam int unsigned MAX_NCH = 16;

    localparam logic [7:0] OFS_CTRL    = 8'h00;
    localparam logic [7:0] OFS_MODE    = 8'h04;
    localparam logic [7:0] OFS_STATUS  = 8'h08;
    localparam logic [7:0] OFS_MASK    = 8'h0C;
    localparam logic [7:0] OFS_TIMEOUT = 8'h10;
    localparam logic [7:0] OFS_TOSTAT  = 8'h14;
    localparam logic [7:0] OFS_COUNT   = 8'h20;

    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_CLR_BIT = 1;

    // Byte offset of COUNT[idx].
    function automatic logic [7:0] count_ofs(input int unsigned idx);
        return OFS_COUNT + 8'(4 * idx);
    endfunction

endpackage

// File: rtl/ef_irq_mon_chan.sv
// ef_irq_mon_chan
//   One monitored interrupt channel: 2-flop synchroniser, history flop for
//   edge detection, sticky STATUS, saturating event COUNT, timeout timer and
//   sticky TOSTAT.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   irq_async              raw interrupt line
//   en, mode_edge, timeout global enable, 1=rising-edge/0=level, timeout limit (0=off)
//   clr_all                clear everything this edge (events lost)
//   status_w1c, tostat_w1c W1C strobes for this channel's bits
//   cnt_wr                 any write to this channel's COUNT register
//   status, tostat, count  register state
module ef_irq_mon_chan
    import ef_irq_mon_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned TO_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             irq_async,
    input  logic             en,
    input  logic             mode_edge,
    input  logic [TO_W-1:0]  timeout,
    input  logic             clr_all,
    input  logic             status_w1c,
    input  logic             tostat_w1c,
    input  logic             cnt_wr,
    output logic             status,
    output logic             tostat,
    output logic [CNT_W-1:0] count
);

    logic            sync1;
    logic            sync2;
    logic            hist;
    logic [TO_W-1:0] timer;

    logic rise;
    logic evt;
    logic to_en;
    logic to_hit;

    always_comb begin
        rise   = sync2 & ~hist;
        evt    = en & (mode_edge ? rise : sync2);
        to_en  = en & (timeout != '0);
        // Covers both the timer stepping onto TIMEOUT this edge and a timer
        // already past a freshly lowered TIMEOUT.
        to_hit = to_en & status & (timer >= (timeout - TO_W'(1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= irq_async;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status <= 1'b0;
            tostat <= 1'b0;
            count  <= '0;
            timer  <= '0;
        end else if (clr_all) begin
            status <= 1'b0;
            tostat <= 1'b0;
            count  <= '0;
            timer  <= '0;
        end else begin
            // Set wins over a coincident W1C.
            status <= (status & ~status_w1c) | evt;
            tostat <= (tostat & ~tostat_w1c) | to_hit;

            if (cnt_wr) begin
                count <= CNT_W'(en & rise);
            end else if (en && rise && (count != '1)) begin
                count <= count + CNT_W'(1);
            end

            if (!status) begin
                timer <= '0;
            end else if (to_en && (timer < timeout)) begin
                timer <= timer + TO_W'(1);
            end
        end
    end

endmodule

// File: rtl/ef_irq_mon_apb.sv
// ef_irq_mon_apb
//   APB-attached interrupt monitor. Watches NCH asynchronous interrupt lines,
//   records sticky status, per-channel event counts and timeout flags, and
//   raises a registered, masked aggregate interrupt.
// Ports:
//   PCLK, PRESETn                     clock, asynchronous active-low reset
//   PADDR, PSEL, PENABLE, PWRITE,
//   PWDATA                            APB request (PADDR[7:0] decoded)
//   PRDATA, PREADY                    APB response (zero wait, combinational read)
//   irq_in                            monitored interrupt lines
//   IRQ                               |((STATUS|TOSTAT) & MASK), registered
module ef_irq_mon_apb
    import ef_irq_mon_pkg::*;
#(
    parameter int unsigned NCH   = 4,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned TO_W  = 16
) (
    input  logic            PCLK,
    input  logic            PRESETn,
    input  logic [31:0]     PADDR,
    input  logic            PSEL,
    input  logic            PENABLE,
    input  logic            PWRITE,
    input  logic [31:0]     PWDATA,
    output logic [31:0]     PRDATA,
    output logic            PREADY,
    input  logic [NCH-1:0]  irq_in,
    output logic            IRQ
);

    logic [7:0] addr;
    logic       wr_en;
    logic       wr_ctrl;
    logic       clr_all;

    logic            en_q;
    logic [NCH-1:0]  mode_q;
    logic [NCH-1:0]  mask_q;
    logic [TO_W-1:0] timeout_q;
    logic            irq_q;

    logic [NCH-1:0]   status;
    logic [NCH-1:0]   tostat;
    logic [CNT_W-1:0] count [NCH];

    logic [31:0] rdata;
    logic        unused_bus;

    assign addr       = PADDR[7:0];
    assign wr_en      = PSEL & PENABLE & PWRITE;
    assign wr_ctrl    = wr_en & (addr == OFS_CTRL);
    assign clr_all    = wr_ctrl & PWDATA[CTRL_CLR_BIT];
    assign unused_bus = ^{PADDR[31:8], PWDATA};

    assign PREADY = 1'b1;
    assign PRDATA = rdata;
    assign IRQ    = irq_q;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        ef_irq_mon_chan #(
            .CNT_W (CNT_W),
            .TO_W  (TO_W)
        ) u_chan (
            .clk        (PCLK),
            .rst_n      (PRESETn),
            .irq_async  (irq_in[g]),
            .en         (en_q),
            .mode_edge  (mode_q[g]),
            .timeout    (timeout_q),
            .clr_all    (clr_all),
            .status_w1c (wr_en && (addr == OFS_STATUS) && PWDATA[g]),
            .tostat_w1c (wr_en && (addr == OFS_TOSTAT) && PWDATA[g]),
            .cnt_wr     (wr_en && (addr == count_ofs(g))),
            .status     (status[g]),
            .tostat     (tostat[g]),
            .count      (count[g])
        );
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            en_q      <= 1'b0;
            mode_q    <= '0;
            mask_q    <= '0;
            timeout_q <= '0;
        end else if (wr_en) begin
            if (addr == OFS_CTRL)    en_q      <= PWDATA[CTRL_EN_BIT];
            if (addr == OFS_MODE)    mode_q    <= PWDATA[NCH-1:0];
            if (addr == OFS_MASK)    mask_q    <= PWDATA[NCH-1:0];
            if (addr == OFS_TIMEOUT) timeout_q <= PWDATA[TO_W-1:0];
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |((status | tostat) & mask_q);
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            OFS_CTRL:    rdata[CTRL_EN_BIT] = en_q;
            OFS_MODE:    rdata[NCH-1:0]     = mode_q;
            OFS_STATUS:  rdata[NCH-1:0]     = status;
            OFS_MASK:    rdata[NCH-1:0]     = mask_q;
            OFS_TIMEOUT: rdata[TO_W-1:0]    = timeout_q;
            OFS_TOSTAT:  rdata[NCH-1:0]     = tostat;
            default:     ;
        endcase
        for (int unsigned i = 0; i < NCH; i++) begin
            if (addr == count_ofs(i)) rdata[CNT_W-1:0] = count[i];
        end
    end

endmodule

// File: tb/tb_ef_irq_mon_apb.sv
`timescale 1ns/10ps
module tb_ef_irq_mon_apb;

    localparam int unsigned NCH   = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned TO_W  = 16;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic           PCLK    = 1'b0;
    logic           PRESETn = 1'b0;
    logic [31:0]    PADDR   = '0;
    logic           PSEL    = 1'b0;
    logic           PENABLE = 1'b0;
    logic           PWRITE  = 1'b0;
    logic [31:0]    PWDATA  = '0;
    logic [31:0]    PRDATA;
    logic           PREADY;
    logic [NCH-1:0] irq_in  = '0;
    logic           IRQ;

    int n_chk = 0;
    int n_bad = 0;

    always #10 PCLK = ~PCLK;

    ef_irq_mon_apb #(
        .NCH   (NCH),
        .CNT_W (CNT_W),
        .TO_W  (TO_W)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PADDR   (PADDR),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .irq_in  (irq_in),
        .IRQ     (IRQ)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // The line as seen by the monitor at a clock edge is the value sampled
    // two edges earlier; the value three edges earlier gives the previous level.
    bit             m_en;
    bit [NCH-1:0]   m_mode, m_mask, m_status, m_tostat;
    int             m_to;
    int             m_cnt [NCH];
    int             m_tmr [NCH];
    bit             m_irq;
    logic [NCH-1:0] seen [$];

    task automatic model_reset();
        m_en = 0; m_mode = '0; m_mask = '0; m_status = '0; m_tostat = '0;
        m_to = 0; m_irq = 0;
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = 0;
            m_tmr[i] = 0;
        end
        seen = '{'0, '0, '0};
    endtask

    task automatic model_step();
        logic [7:0]     a;
        logic [NCH-1:0] lvl, rise;
        bit             wr_now, clr, nirq;
        bit [NCH-1:0]   ns, nt;
        int             nc [NCH];
        int             ntm [NCH];
        a      = PADDR[7:0];
        wr_now = PSEL && PENABLE && PWRITE;
        clr    = wr_now && (a == 8'h00) && PWDATA[1];
        lvl    = seen[1];
        rise   = seen[1] & ~seen[2];
        nirq   = |((m_status | m_tostat) & m_mask);
        for (int i = 0; i < NCH; i++) begin
            bit ev, sw, tw, cw;
            ev = m_en && (m_mode[i] ? rise[i] : lvl[i]);
            sw = wr_now && (a == 8'h08) && PWDATA[i];
            tw = wr_now && (a == 8'h14) && PWDATA[i];
            cw = wr_now && (a == 8'(8'h20 + 4 * i));
            if (clr) begin
                ns[i] = 0; nt[i] = 0; nc[i] = 0; ntm[i] = 0;
            end else begin
                ns[i] = (m_status[i] && !sw) || ev;
                if (cw)                  nc[i] = (m_en && rise[i]) ? 1 : 0;
                else if (m_en && rise[i]) nc[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
                else                     nc[i] = m_cnt[i];
                if (!m_status[i])                             ntm[i] = 0;
                else if (m_en && m_to != 0 && m_tmr[i] < m_to) ntm[i] = m_tmr[i] + 1;
                else                                          ntm[i] = m_tmr[i];
                nt[i] = (m_tostat[i] && !tw) ||
                        (m_en && m_status[i] && m_to != 0 && m_tmr[i] + 1 >= m_to);
            end
        end
        m_status = ns;
        m_tostat = nt;
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = nc[i];
            m_tmr[i] = ntm[i];
        end
        if (wr_now) begin
            if (a == 8'h00) m_en   = PWDATA[0];
            if (a == 8'h04) m_mode = PWDATA[NCH-1:0];
            if (a == 8'h0C) m_mask = PWDATA[NCH-1:0];
            if (a == 8'h10) m_to   = int'(PWDATA[TO_W-1:0]);
        end
        m_irq = nirq;
        seen.push_front(irq_in);
        void'(seen.pop_back());
    endtask

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) model_reset();
        else          model_step();
    end

    function automatic logic [31:0] exp_reg(input logic [7:0] a);
        case (a)
            8'h00: return {31'b0, m_en};
            8'h04: return 32'(m_mode);
            8'h08: return 32'(m_status);
            8'h0C: return 32'(m_mask);
            8'h10: return 32'(m_to);
            8'h14: return 32'(m_tostat);
            default: begin
                for (int i = 0; i < NCH; i++)
                    if (a == 8'(8'h20 + 4 * i)) return 32'(m_cnt[i]);
                return 32'h0;
            end
        endcase
    endfunction

    // ---------------- bus helpers ----------------
    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        PADDR = {24'h0, a};
        #0.1;
        d = PRDATA;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = {24'h0, a}; PWDATA = d;
        @(negedge PCLK);
        PENABLE = 1;
        @(negedge PCLK);
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic cmp_all(input string tag);
        logic [7:0]  al [11];
        logic [31:0] d;
        al = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h20, 8'h24, 8'h28, 8'h2C};
        foreach (al[k]) begin
            rd(al[k], d);
            chk($sformatf("%s@%02h", tag, al[k]), d, exp_reg(al[k]));
        end
        chk({tag, ".irq"}, 32'(IRQ), 32'(m_irq));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog time limit expired");
        $display("test done: total=%0d bad=%0d", n_chk, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          n;
        bit          hit;

        cyc(3);
        cmp_all("rst");
        chk("pready", 32'(PREADY), 32'h1);
        PRESETn = 1;

        // Edge mode, 5-cycle pulse on ch2, mask ch2.
        wr(8'h00, 1); wr(8'h04, 'hF); wr(8'h0C, 'h4);
        irq_in[2] = 1;
        cyc(2); rd(8'h08, d); chk("pulse.edge2", d, 32'h0);
        cyc(1); rd(8'h08, d); chk("pulse.edge3", d, 32'h4);
        chk("pulse.irq_early", 32'(IRQ), 32'h0);
        cyc(1); chk("pulse.irq", 32'(IRQ), 32'h1);
        cyc(1); irq_in[2] = 0;
        cyc(4); rd(8'h28, d); chk("pulse.count2", d, 32'h1);
        cmp_all("pulse");

        // Level mode: W1C cannot clear while the line is high.
        wr(8'h00, 3); wr(8'h04, 0);
        irq_in[0] = 1;
        cyc(4); wr(8'h08, 1);
        rd(8'h08, d); chk("lvl.held", d, 32'h1);
        irq_in[0] = 0;
        cyc(4); wr(8'h08, 1);
        rd(8'h08, d); chk("lvl.clr", d, 32'h0);
        cmp_all("lvl");

        // Saturation and count write coinciding with an event.
        wr(8'h04, 'hF);
        for (int k = 0; k < 20; k++) begin
            irq_in[1] = 1; cyc(2);
            irq_in[1] = 0; cyc(2);
        end
        cyc(3); rd(8'h24, d); chk("sat.count1", d, 32'(CMAX));
        irq_in[1] = 1;
        wr(8'h24, 0);
        rd(8'h24, d); chk("sat.wr_evt", d, 32'h1);
        irq_in[1] = 0;
        cmp_all("sat");

        // Timeout on ch3.
        wr(8'h00, 3); wr(8'h10, 10); wr(8'h0C, 'h8);
        irq_in[3] = 1;
        n = 0; hit = 0;
        while (!hit && n < 10) begin cyc(1); n++; rd(8'h08, d); hit = d[3]; end
        chk("to.status_set", 32'(hit), 32'h1);
        n = 0; hit = 0;
        while (!hit && n < 20) begin cyc(1); n++; rd(8'h14, d); hit = d[3]; end
        chk("to.latency", 32'(n), 32'd10);
        chk("to.tostat", d, 32'h8);
        irq_in[3] = 0;
        wr(8'h08, 8); cyc(15);
        rd(8'h14, d); chk("to.sticky", d, 32'h8);
        rd(8'h08, d); chk("to.status_clr", d, 32'h0);
        wr(8'h14, 8); cyc(15);
        rd(8'h14, d); chk("to.cleared", d, 32'h0);
        chk("to.irq", 32'(IRQ), 32'h0);
        cmp_all("to");

        // Lowering TIMEOUT below a running timer.
        wr(8'h10, 'h40); wr(8'h0C, 'h1);
        irq_in[0] = 1; cyc(20); irq_in[0] = 0;
        rd(8'h14, d); chk("tolow.before", d, 32'h0);
        wr(8'h10, 5);
        rd(8'h14, d); chk("tolow.same", d, 32'h0);
        cyc(1); rd(8'h14, d); chk("tolow.next", d, 32'h1);
        cmp_all("tolow");

        // EN=0 ignores events; CLR_ALL drops a concurrent event.
        wr(8'h00, 3); wr(8'h00, 0);
        for (int k = 0; k < 3; k++) begin
            irq_in = '1; cyc(2); irq_in = '0; cyc(2);
        end
        cyc(3); rd(8'h08, d); chk("dis.status", d, 32'h0);
        cmp_all("dis");
        wr(8'h00, 1);
        irq_in = '1;
        wr(8'h00, 3);
        cyc(3); rd(8'h08, d); chk("clr.status", d, 32'h0);
        for (int i = 0; i < NCH; i++) begin
            rd(8'(8'h20 + 4 * i), d); chk($sformatf("clr.count%0d", i), d, 32'h0);
        end
        irq_in = '0;
        cmp_all("clr");

        // Randomized traffic against the model.
        wr(8'h00, 1); wr(8'h10, 0);
        for (int c = 0; c < 1500; c++) begin
            @(negedge PCLK);
            for (int b = 0; b < NCH; b++)
                if ($urandom_range(3) == 0) irq_in[b] = ~irq_in[b];
            if ($urandom_range(5) == 0) begin
                case ($urandom_range(9))
                    0:       wr(8'h04, $urandom);
                    1:       wr(8'h0C, $urandom);
                    2, 3:    wr(8'h08, $urandom);
                    4:       wr(8'h14, $urandom);
                    5:       wr(8'h10, $urandom_range(12));
                    6:       wr(8'(8'h20 + 4 * $urandom_range(3)), $urandom);
                    7:       wr(8'h00, ($urandom_range(9) == 0) ? 3 :
                                       (($urandom_range(7) == 0) ? 0 : 1));
                    default: wr(8'h18, $urandom);
                endcase
            end
            if (c % 10 == 0) cmp_all("rnd");
        end

        // Asynchronous reset mid-burst.
        wr(8'h0C, 'hF); wr(8'h04, 'hF); wr(8'h00, 1);
        irq_in = '0; cyc(3); irq_in = '1; cyc(4);
        chk("arst.irq_pre", 32'(IRQ), 32'h1);
        @(negedge PCLK);
        irq_in = 4'h5;
        #2 PRESETn = 0;
        #0.1;
        chk("arst.irq", 32'(IRQ), 32'h0);
        rd(8'h08, d); chk("arst.status", d, 32'h0);
        cmp_all("arst");
        cyc(2);
        PRESETn = 1;
        irq_in = '0;
        wr(8'h00, 1); wr(8'h04, 'hA); wr(8'h0C, 'hF);
        for (int c = 0; c < 200; c++) begin
            @(negedge PCLK);
            irq_in = NCH'($urandom);
            if (c % 10 == 0) cmp_all("post");
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
